// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes and
// the datapath select codes driven by the state decode.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RCOMP  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic logic is_supported(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Purely combinational Moore decode: control strobes and selects as a
// function of the current state only.
module mc_ctrl_outputs
   import mc_ctrl_pkg::*;
(
   input  state_t     state,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource
);

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REG;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            ALUSrcB = SRCB_FOUR;
         end
         // DECODE speculatively forms the branch target into ALUOut
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH2;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_RCOMP: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_ADDIWB: begin
            RegWrite = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: next-state logic, state register and the
// retired-instruction counter, with the output decode in mc_ctrl_outputs.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   state_t cur_state;
   state_t next_state;
   logic   retire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_FETCH;
      end else begin
         cur_state <= next_state;
      end
   end

   always_comb begin
      next_state = S_FETCH;
      illegal    = 1'b0;
      retire     = 1'b0;
      case (cur_state)
         S_FETCH: next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_RTYPE:     next_state = S_EXEC;
               OP_BEQ:       next_state = S_BRANCH;
               OP_J:         next_state = S_JUMP;
               OP_ADDI:      next_state = S_ADDIEX;
               default:      next_state = S_FETCH;
            endcase
            illegal = !is_supported(opcode);
         end
         // Only lw and sw can reach MEMADR, and the IR holds the opcode steady
         S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  next_state = S_MEMWB;
         S_EXEC:   next_state = S_RCOMP;
         S_ADDIEX: next_state = S_ADDIWB;
         S_MEMWB, S_MEMWR, S_RCOMP, S_BRANCH, S_JUMP, S_ADDIWB: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         default: next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired <= '0;
      end else if (retire) begin
         retired <= retired + 1'b1;
      end
   end

   assign state = cur_state;

   mc_ctrl_outputs u_outputs (
      .state       (cur_state),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .RegDst      (RegDst),
      .RegWrite    (RegWrite),
      .ALUSrcA     (ALUSrcA),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .PCSource    (PCSource)
   );

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues per-cycle expected
// snapshots, a negedge monitor pops and compares them.
module tb_mc_control_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic        illegal;
   logic [3:0]  state;
   logic [31:0] retired;

   logic        s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead, s_MemWrite, s_IRWrite;
   logic        s_MemtoReg, s_RegDst, s_RegWrite, s_ALUSrcA;
   logic [1:0]  s_ALUSrcB, s_ALUOp, s_PCSource;
   logic        s_illegal;
   logic [3:0]  s_state;
   logic [3:0]  s_retired;

   logic [15:0] ctrl_vec;

   typedef struct {
      logic [3:0]  state;
      logic [15:0] ctrl;
      logic        illegal;
      logic [31:0] retired;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_retired = 0;

   always #5 clk = ~clk;

   mc_control_fsm #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .illegal(illegal), .state(state),
      .retired(retired)
   );

   mc_control_fsm #(.CNT_W(4)) dut_small (
      .clk(clk), .rst(rst), .opcode(opcode),
      .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IorD(s_IorD),
      .MemRead(s_MemRead), .MemWrite(s_MemWrite), .IRWrite(s_IRWrite),
      .MemtoReg(s_MemtoReg), .RegDst(s_RegDst), .RegWrite(s_RegWrite),
      .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .ALUOp(s_ALUOp),
      .PCSource(s_PCSource), .illegal(s_illegal), .state(s_state),
      .retired(s_retired)
   );

   assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

   // Hand-written control words, bit order as in ctrl_vec
   function automatic logic [15:0] ctrl_for(input logic [3:0] st);
      case (st)
         4'd0:    return 16'h9410;
         4'd1:    return 16'h0030;
         4'd2:    return 16'h0060;
         4'd3:    return 16'h3000;
         4'd4:    return 16'h0280;
         4'd5:    return 16'h2800;
         4'd6:    return 16'h0048;
         4'd7:    return 16'h0180;
         4'd8:    return 16'h4045;
         4'd9:    return 16'h8002;
         4'd10:   return 16'h0060;
         4'd11:   return 16'h0080;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_output("state", {28'd0, state}, {28'd0, e.state});
         check_output("ctrl", {16'd0, ctrl_vec}, {16'd0, e.ctrl});
         check_output("illegal", {31'd0, illegal}, {31'd0, e.illegal});
         check_output("retired", retired, e.retired);
         check_output("retired4", {28'd0, s_retired}, {28'd0, e.retired[3:0]});
      end
   end

   // seq lists up to six expected states, one nibble each, first state in the top nibble
   task automatic apply_stimulus(input logic [5:0] op, input logic [23:0] seq,
                                 input int len, input bit bad);
      exp_t e;
      opcode = op;
      for (int i = 0; i < len; i++) begin
         e.state   = seq[23-4*i -: 4];
         e.ctrl    = ctrl_for(e.state);
         e.illegal = bad && (i == 1);
         e.retired = exp_retired;
         exp_q.push_back(e);
      end
      if (!bad) exp_retired = exp_retired + 1;
      repeat (len) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      exp_t e;
      rst    = 1'b1;
      opcode = 6'b000000;
      #3;
      check_output("rst_state", {28'd0, state}, 32'd0);
      check_output("rst_ctrl", {16'd0, ctrl_vec}, 32'h9410);
      check_output("rst_retired", retired, 32'd0);
      check_output("rst_illegal", {31'd0, illegal}, 32'd0);

      @(posedge clk);
      #1;
      rst = 1'b0;

      apply_stimulus(6'b100011, 24'h012340, 5, 1'b0);
      apply_stimulus(6'b101011, 24'h012500, 4, 1'b0);
      apply_stimulus(6'b000000, 24'h016700, 4, 1'b0);
      apply_stimulus(6'b000100, 24'h018000, 3, 1'b0);
      apply_stimulus(6'b000010, 24'h019000, 3, 1'b0);
      apply_stimulus(6'b001000, 24'h01AB00, 4, 1'b0);
      apply_stimulus(6'b111111, 24'h010000, 2, 1'b1);
      apply_stimulus(6'b000010, 24'h019000, 3, 1'b0);

      // Abandon an lw in MEMRD with an asynchronous reset between edges
      opcode = 6'b100011;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check_output("pre_rst_state", {28'd0, state}, 32'd3);
      check_output("pre_rst_retired", retired, 32'd7);
      #2;
      rst = 1'b1;
      #1;
      check_output("mid_rst_state", {28'd0, state}, 32'd0);
      check_output("mid_rst_retired", retired, 32'd0);
      check_output("mid_rst_irwrite", {31'd0, IRWrite}, 32'd1);
      check_output("mid_rst_retired4", {28'd0, s_retired}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_retired = 0;

      for (int k = 0; k < 16; k++) begin
         apply_stimulus(6'b000010, 24'h019000, 3, 1'b0);
      end
      apply_stimulus(6'b101011, 24'h012500, 4, 1'b0);
      check_output("wrap_retired4", {28'd0, s_retired}, 32'd1);
      check_output("final_retired", retired, 32'd17);

      e.state   = 4'd0;
      e.ctrl    = ctrl_for(4'd0);
      e.illegal = 1'b0;
      e.retired = exp_retired;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_output("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
